// File: rtl/train_sequencer.sv
// -----------------------------------------------------------------------------
// train_sequencer
//   Top-level run controller for the layer pipeline. A run is NS samples per
//   epoch over NE epochs (training) or a single epoch (inference). Sample
//   addresses go to the input-side sample memory over a valid/ready handshake.
//   Completion tokens from the network tail retire in-flight samples. The
//   number of outstanding samples is bounded by DEPTH, or by 1 when
//   BURST="no". The pipeline is fully drained at every epoch boundary.
//
// Ports
//   iCLK, iRST          clock (rising edge), asynchronous active-low reset
//   iStart, iTrain      run request and run type (1=train), sampled in IDLE
//   oMode, oLR          network-wide mode and learning-rate select
//   oValid_BM_Sample    sample issue valid
//   iReady_BM_Sample    sample issue ready
//   oData_BM_Sample     sample address
//   iValid_AM_Done      completion token valid from the network tail
//   oReady_AM_Done      completion token accept
//   oEpoch              current epoch index
//   oBusy               run active
//   oDone               one-cycle pulse at run end
// -----------------------------------------------------------------------------
module train_sequencer #(
    parameter int    NS        = 16,
    parameter int    NE        = 8,
    parameter int    LR_EPOCHS = 4,
    parameter int    DEPTH     = 4,
    parameter string BURST     = "yes"
) (
    input  logic                      iCLK,
    input  logic                      iRST,
    input  logic                      iStart,
    input  logic                      iTrain,
    output logic                      oMode,
    output logic                      oLR,
    output logic                      oValid_BM_Sample,
    input  logic                      iReady_BM_Sample,
    output logic [$clog2(NS)-1:0]     oData_BM_Sample,
    input  logic                      iValid_AM_Done,
    output logic                      oReady_AM_Done,
    output logic [$clog2(NE+1)-1:0]   oEpoch,
    output logic                      oBusy,
    output logic                      oDone
);

    localparam int AW    = $clog2(NS);
    localparam int EW    = $clog2(NE + 1);
    localparam int LIMIT = (BURST == "no") ? 1 : DEPTH;
    localparam int FW    = $clog2(LIMIT + 1);

    localparam logic [FW-1:0] LIMIT_W   = FW'(LIMIT);
    localparam logic [AW-1:0] LAST_IDX  = AW'(NS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_reg,    state_next;
    logic            mode_reg,     mode_next;
    logic [AW-1:0]   idx_reg,      idx_next;
    logic [EW-1:0]   epoch_reg,    epoch_next;
    logic [FW-1:0]   inflight_reg, inflight_next;

    logic issue_fire;
    logic done_fire;
    logic last_epoch;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_reg    <= S_IDLE;
            mode_reg     <= 1'b0;
            idx_reg      <= '0;
            epoch_reg    <= '0;
            inflight_reg <= '0;
        end else begin
            state_reg    <= state_next;
            mode_reg     <= mode_next;
            idx_reg      <= idx_next;
            epoch_reg    <= epoch_next;
            inflight_reg <= inflight_next;
        end
    end

    // Outputs are pure decodes of registered state, so oValid stays high with
    // a stable address until accepted: nothing but an issue can raise inflight.
    always_comb begin
        oValid_BM_Sample = (state_reg == S_ISSUE) && (inflight_reg < LIMIT_W);
        oReady_AM_Done   = ((state_reg == S_ISSUE) || (state_reg == S_DRAIN))
                           && (inflight_reg != '0);
        oData_BM_Sample  = idx_reg;
        oMode            = mode_reg;
        oLR              = mode_reg && (int'(epoch_reg) < LR_EPOCHS);
        oEpoch           = epoch_reg;
        oBusy            = (state_reg == S_ISSUE) || (state_reg == S_DRAIN);
        oDone            = (state_reg == S_DONE);
    end

    assign issue_fire = oValid_BM_Sample && iReady_BM_Sample;
    assign done_fire  = iValid_AM_Done && oReady_AM_Done;
    // Inference runs are a single epoch regardless of NE.
    assign last_epoch = mode_reg ? (int'(epoch_reg) + 1 >= NE) : 1'b1;

    always_comb begin
        state_next    = state_reg;
        mode_next     = mode_reg;
        idx_next      = idx_reg;
        epoch_next    = epoch_reg;
        inflight_next = inflight_reg;

        // Issue and completion in the same cycle cancel out.
        case ({issue_fire, done_fire})
            2'b10:   inflight_next = inflight_reg + FW'(1);
            2'b01:   inflight_next = inflight_reg - FW'(1);
            default: inflight_next = inflight_reg;
        endcase

        case (state_reg)
            S_IDLE: begin
                if (iStart) begin
                    state_next    = S_ISSUE;
                    mode_next     = iTrain;
                    idx_next      = '0;
                    epoch_next    = '0;
                    inflight_next = '0;
                end
            end
            S_ISSUE: begin
                if (issue_fire) begin
                    if (idx_reg == LAST_IDX) begin
                        idx_next   = '0;
                        state_next = S_DRAIN;
                    end else begin
                        idx_next = idx_reg + AW'(1);
                    end
                end
            end
            S_DRAIN: begin
                // Epoch only advances once empty, so oLR never changes
                // underneath a sample still in the network.
                if (inflight_reg == '0) begin
                    if (last_epoch) begin
                        state_next = S_DONE;
                    end else begin
                        epoch_next = epoch_reg + EW'(1);
                        state_next = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_train_sequencer.sv
// -----------------------------------------------------------------------------
// tb_train_sequencer
//   Directed bench for train_sequencer. A default-parameter instance covers
//   inference, training with backpressure, spurious completions and mid-run
//   reset; a small BURST="no" instance covers the single-outstanding mode.
//   The sample-memory/network side is modelled by a queue that returns a
//   completion a fixed number of cycles after each issue.
// -----------------------------------------------------------------------------
module tb_train_sequencer;

    localparam int NS    = 16;
    localparam int NE    = 8;
    localparam int LRE   = 4;
    localparam int DEPTH = 4;
    localparam int LAT   = 4;   // cycles from issue to completion offered

    localparam int NB_NS = 4;
    localparam int NB_NE = 2;
    localparam int NB_LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic       rst_n, start, train, ready, done_in;
    logic       mode, lr, valid, done_ready, busy, run_done;
    logic [3:0] addr;
    logic [3:0] epoch;

    // BURST="no" instance
    logic       nb_start, nb_train, nb_ready, nb_done_in;
    logic       nb_mode, nb_lr, nb_valid, nb_done_ready, nb_busy, nb_run_done;
    logic [1:0] nb_addr;
    logic [1:0] nb_epoch;

    train_sequencer #(.NS(NS), .NE(NE), .LR_EPOCHS(LRE), .DEPTH(DEPTH), .BURST("yes")) u_dut (
        .iCLK(clk), .iRST(rst_n), .iStart(start), .iTrain(train),
        .oMode(mode), .oLR(lr), .oValid_BM_Sample(valid), .iReady_BM_Sample(ready),
        .oData_BM_Sample(addr), .iValid_AM_Done(done_in), .oReady_AM_Done(done_ready),
        .oEpoch(epoch), .oBusy(busy), .oDone(run_done)
    );

    train_sequencer #(.NS(NB_NS), .NE(NB_NE), .LR_EPOCHS(1), .DEPTH(DEPTH), .BURST("no")) u_nb (
        .iCLK(clk), .iRST(rst_n), .iStart(nb_start), .iTrain(nb_train),
        .oMode(nb_mode), .oLR(nb_lr), .oValid_BM_Sample(nb_valid), .iReady_BM_Sample(nb_ready),
        .oData_BM_Sample(nb_addr), .iValid_AM_Done(nb_done_in), .oReady_AM_Done(nb_done_ready),
        .oEpoch(nb_epoch), .oBusy(nb_busy), .oDone(nb_run_done)
    );

    int tests = 0;
    int fails = 0;

    // model state for the main instance
    int cyc;
    int mdl_inflight;
    int peak;
    int issues;
    int completions;
    int exp_idx;
    int done_pulses;
    int simul_hits;
    bit mode_exp;
    int due_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_done();
        done_in = (due_q.size() > 0) && (due_q[0] <= cyc);
    endtask

    task automatic reset_model(input bit tr);
        cyc = 0; mdl_inflight = 0; peak = 0; issues = 0; completions = 0;
        exp_idx = 0; done_pulses = 0; simul_hits = 0; mode_exp = tr;
        due_q.delete();
        done_in = 1'b0;
    endtask

    // One clock of the main instance: record handshakes before the edge,
    // advance, then update the model and check invariants after the edge.
    task automatic step();
        bit iss, dn;
        int pre;
        @(negedge clk);
        iss = (valid === 1'b1) && (ready === 1'b1);
        dn  = (done_in === 1'b1) && (done_ready === 1'b1);
        pre = mdl_inflight;
        if (iss) begin
            check("issue_addr", 32'(addr), exp_idx);
            check("issue_epoch", 32'(epoch), issues / NS);
            check("issue_lr", 32'(lr), 32'(mode_exp && (issues / NS < LRE)));
            check("issue_mode", 32'(mode), 32'(mode_exp));
            if (issues % NS == 0) check("issue_after_drain", pre, 0);
            exp_idx = (exp_idx + 1) % NS;
            issues++;
            due_q.push_back(cyc + LAT);
        end
        if (dn) begin
            void'(due_q.pop_front());
            completions++;
        end
        @(posedge clk);
        #1;
        cyc++;
        mdl_inflight = pre + int'(iss) - int'(dn);
        if (mdl_inflight > peak) peak = mdl_inflight;
        check("ready_vs_inflight", 32'(done_ready), 32'(mdl_inflight > 0));
        if (mdl_inflight >= DEPTH) check("valid_at_limit", 32'(valid), 0);
        if (iss && dn && pre == DEPTH - 1 && issues % NS != 0) begin
            simul_hits++;
            check("simul_valid", 32'(valid), 1);
        end
        if (run_done === 1'b1) done_pulses++;
        drive_done();
    endtask

    // Full run from IDLE to the cycle after oDone. bp_at<0 disables the stall.
    task automatic run(input bit tr, input int n_expect, input int bp_at);
        bit finished;
        bit bp_done;
        logic [3:0] held;
        finished = 1'b0;
        bp_done  = 1'b0;
        reset_model(tr);
        ready = 1'b1;
        start = 1'b1;
        train = tr;
        step();
        start = 1'b0;
        train = ~tr;   // must be ignored outside IDLE
        check("first_valid", 32'(valid), 1);
        check("first_busy", 32'(busy), 1);
        check("first_addr", 32'(addr), 0);
        check("first_mode", 32'(mode), 32'(tr));
        for (int k = 0; k < 4000 && !finished; k++) begin
            if (bp_at >= 0 && !bp_done && issues == bp_at && valid === 1'b1) begin
                held  = addr;
                ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    step();
                    check("bp_addr_stable", 32'(addr), 32'(held));
                    check("bp_valid_held", 32'(valid), 1);
                end
                ready   = 1'b1;
                bp_done = 1'b1;
            end
            step();
            if (run_done === 1'b1) finished = 1'b1;
        end
        check("run_timeout", 32'(finished), 1);
        check("run_issues", issues, n_expect);
        check("run_completions", completions, n_expect);
        check("done_busy", 32'(busy), 0);
        check("done_epoch", 32'(epoch), tr ? NE - 1 : 0);
        check("done_lr", 32'(lr), 0);
        check("done_mode", 32'(mode), 32'(tr));
        step();
        check("done_one_cycle", 32'(run_done), 0);
        check("done_pulses", done_pulses, 1);
        check("idle_epoch_hold", 32'(epoch), tr ? NE - 1 : 0);
        check("idle_mode_hold", 32'(mode), 32'(tr));
    endtask

    int nb_cyc, nb_inf, nb_issues, nb_idx;
    bit nb_fin;
    int nb_q[$];
    bit iss_b, dn_b;
    bit hit;

    initial begin
        rst_n = 1'b0; start = 1'b0; train = 1'b0; ready = 1'b1; done_in = 1'b0;
        nb_start = 1'b0; nb_train = 1'b0; nb_ready = 1'b1; nb_done_in = 1'b0;
        cyc = 0;

        // --- reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_mode", 32'(mode), 0);
        check("rst_lr", 32'(lr), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_addr", 32'(addr), 0);
        check("rst_ready", 32'(done_ready), 0);
        check("rst_epoch", 32'(epoch), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(run_done), 0);
        rst_n = 1'b1;

        // --- spurious completion in IDLE
        done_in = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("spur_ready", 32'(done_ready), 0);
            check("spur_busy", 32'(busy), 0);
            check("spur_valid", 32'(valid), 0);
        end
        done_in = 1'b0;

        // --- inference run
        run(1'b0, NS, -1);
        check("inf_peak", peak, DEPTH);
        check("inf_simul_seen", 32'(simul_hits > 0), 1);

        // --- training run with a 5-cycle backpressure stall in epoch 1
        run(1'b1, NS * NE, 20);

        // --- reset in epoch 2 with 3 in flight
        reset_model(1'b1);
        start = 1'b1; train = 1'b1;
        step();
        start = 1'b0; train = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 2000 && !hit; k++) begin
            step();
            if (epoch === 4'd2 && mdl_inflight == 3) hit = 1'b1;
        end
        check("mid_reached", 32'(hit), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_mode", 32'(mode), 0);
        check("arst_lr", 32'(lr), 0);
        check("arst_valid", 32'(valid), 0);
        check("arst_ready", 32'(done_ready), 0);
        check("arst_epoch", 32'(epoch), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_addr", 32'(addr), 0);
        due_q.delete();
        done_in = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(1'b0, NS, -1);

        // --- BURST="no" instance, 2 training epochs of 4 samples
        nb_cyc = 0; nb_inf = 0; nb_issues = 0; nb_idx = 0; nb_fin = 1'b0;
        nb_start = 1'b1; nb_train = 1'b1;
        @(posedge clk);
        #1;
        nb_start = 1'b0; nb_train = 1'b0;
        for (int k = 0; k < 500 && !nb_fin; k++) begin
            @(negedge clk);
            iss_b = (nb_valid === 1'b1) && (nb_ready === 1'b1);
            dn_b  = (nb_done_in === 1'b1) && (nb_done_ready === 1'b1);
            if (iss_b) begin
                check("nb_no_double_issue", nb_inf, 0);
                check("nb_addr", 32'(nb_addr), nb_idx);
                nb_idx = (nb_idx + 1) % NB_NS;
                nb_issues++;
                nb_q.push_back(nb_cyc + NB_LAT);
            end
            if (dn_b) void'(nb_q.pop_front());
            @(posedge clk);
            #1;
            nb_cyc++;
            nb_inf = nb_inf + int'(iss_b) - int'(dn_b);
            if (nb_inf == 1) check("nb_valid_drop", 32'(nb_valid), 0);
            if (nb_run_done === 1'b1) nb_fin = 1'b1;
            nb_done_in = (nb_q.size() > 0) && (nb_q[0] <= nb_cyc);
        end
        check("nb_timeout", 32'(nb_fin), 1);
        check("nb_issues", nb_issues, NB_NS * NB_NE);
        check("nb_epoch_final", 32'(nb_epoch), NB_NE - 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
